// File: rtl/pixel_compositor.sv
// Output-stage compositor: picks the frame source, layers overlays over live video and
// delays the raw syncs to match. Source/latency changes wait for a frame start, then one muted frame.
module pixel_compositor #(
   parameter int PIX_W      = 24,
   parameter int NUM_LAYERS = 4,
   parameter int MAX_DLY    = 64,
   parameter int DLY_W      = 6,
   parameter int BAR_SHIFT  = 7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  src_sel,
   input  logic [PIX_W-1:0]            live_pixel,
   input  logic [DLY_W-1:0]            live_dly,
   input  logic [7:0]                  bram_dout,
   input  logic                        in_display,
   input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix,
   input  logic [NUM_LAYERS-1:0]       layer_en,
   input  logic                        hsync,
   input  logic                        vsync,
   input  logic                        blank,
   output logic [PIX_W-1:0]            pixel_out,
   output logic                        hsync_out,
   output logic                        vsync_out,
   output logic                        blank_out,
   output logic                        realign,
   output logic [DLY_W-1:0]            dly_active
);
   localparam int CH_W  = PIX_W / 3;
   localparam int COL_W = BAR_SHIFT + 3;
   localparam logic [DLY_W:0] DLY_LIMIT = (DLY_W+1)'(MAX_DLY - 1);
   localparam logic [1:0] SRC_LIVE = 2'd0;
   localparam logic [1:0] SRC_BRAM = 2'd1;
   localparam logic [1:0] SRC_MUTE = 2'd2;
   localparam logic [1:0] SRC_BARS = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_WAIT_VS    = 2'd1,
      ST_MUTE_FRAME = 2'd2
   } state_t;

   state_t           state_r;
   logic             realign_r;
   logic [DLY_W-1:0] dly_active_r;
   logic [1:0]       src_active_r;
   logic             vsync_q_r;
   logic [2:0]       dline_r [1:MAX_DLY-1];
   logic [2:0]       sync_out_r;
   logic [PIX_W-1:0] pixel_r;
   logic [COL_W-1:0] col_r;

   logic [DLY_W-1:0] eff_dly_s;
   logic             fs_s;
   logic             mismatch_s;
   logic [2:0]       tap_s;
   logic [2:0]       bar_idx_s;
   logic [PIX_W-1:0] ovl_s;
   logic [PIX_W-1:0] bram_pix_s;
   logic [PIX_W-1:0] bars_pix_s;
   logic [PIX_W-1:0] sel_pix_s;

   assign fs_s       = ~vsync & vsync_q_r;
   assign mismatch_s = (eff_dly_s != dly_active_r) || (src_sel != src_active_r);
   assign bar_idx_s  = col_r[BAR_SHIFT +: 3];
   assign bars_pix_s = {{CH_W{bar_idx_s[2]}}, {CH_W{bar_idx_s[1]}}, {CH_W{bar_idx_s[0]}}};

   assign pixel_out  = pixel_r;
   assign hsync_out  = sync_out_r[2];
   assign vsync_out  = sync_out_r[1];
   assign blank_out  = sync_out_r[0];
   assign realign    = realign_r;
   assign dly_active = dly_active_r;

   // Clamp the requested latency to the deepest delay-line tap.
   always_comb begin
      if ({1'b0, live_dly} > DLY_LIMIT) begin
         eff_dly_s = DLY_LIMIT[DLY_W-1:0];
      end else begin
         eff_dly_s = live_dly;
      end
   end

   // Sync tap: zero latency bypasses the line so the output register alone gives one cycle.
   always_comb begin
      if (dly_active_r == {DLY_W{1'b0}}) begin
         tap_s = {hsync, vsync, blank};
      end else begin
         tap_s = dline_r[dly_active_r];
      end
   end

   // Overlay priority: scan from the top layer down so the lowest index wins.
   always_comb begin
      ovl_s = live_pixel;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_en[i] && (layer_pix[i*PIX_W +: PIX_W] != {PIX_W{1'b0}})) begin
            ovl_s = layer_pix[i*PIX_W +: PIX_W];
         end else begin
            ovl_s = ovl_s;
         end
      end
   end

   // RRRGGGBB expanded into channel MSBs; outside the stored image shows white.
   always_comb begin
      if (in_display) begin
         bram_pix_s = {bram_dout[7:5], {(CH_W-3){1'b0}},
                       bram_dout[4:2], {(CH_W-3){1'b0}},
                       bram_dout[1:0], {(CH_W-2){1'b0}}};
      end else begin
         bram_pix_s = {PIX_W{1'b1}};
      end
   end

   // Source multiplexer for the active source.
   always_comb begin
      case (src_active_r)
         SRC_LIVE: sel_pix_s = ovl_s;
         SRC_BRAM: sel_pix_s = bram_pix_s;
         SRC_BARS: sel_pix_s = bars_pix_s;
         default:  sel_pix_s = {PIX_W{1'b0}};
      endcase
   end

   // Frame-start detector history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q_r <= 1'b1;
      end else begin
         vsync_q_r <= vsync;
      end
   end

   // Sync delay line, idle-filled on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < MAX_DLY; i++) begin
            dline_r[i] <= 3'b111;
         end
      end else begin
         dline_r[1] <= {hsync, vsync, blank};
         for (int i = 2; i < MAX_DLY; i++) begin
            dline_r[i] <= dline_r[i-1];
         end
      end
   end

   // Colour-bar column counter, restarted by the aligned blank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_r <= {COL_W{1'b0}};
      end else if (tap_s[0]) begin
         col_r <= {COL_W{1'b0}};
      end else begin
         col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
      end
   end

   // Output registers; pixels are forced black outside RUN, syncs never are.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_out_r <= 3'b111;
         pixel_r    <= {PIX_W{1'b0}};
      end else begin
         sync_out_r <= tap_s;
         if (state_r == ST_RUN) begin
            pixel_r <= sel_pix_s;
         end else begin
            pixel_r <= {PIX_W{1'b0}};
         end
      end
   end

   // Realign FSM: changes are latched only on a frame start, then one frame stays muted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_WAIT_VS;
         realign_r    <= 1'b1;
         dly_active_r <= {DLY_W{1'b0}};
         src_active_r <= SRC_MUTE;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mismatch_s && fs_s) begin
                  dly_active_r <= eff_dly_s;
                  src_active_r <= src_sel;
                  state_r      <= ST_MUTE_FRAME;
                  realign_r    <= 1'b1;
               end else if (mismatch_s) begin
                  state_r      <= ST_WAIT_VS;
                  realign_r    <= 1'b1;
               end else begin
                  state_r      <= ST_RUN;
                  realign_r    <= 1'b0;
               end
            end
            ST_WAIT_VS: begin
               realign_r <= 1'b1;
               if (fs_s) begin
                  dly_active_r <= eff_dly_s;
                  src_active_r <= src_sel;
                  state_r      <= ST_MUTE_FRAME;
               end else begin
                  state_r      <= ST_WAIT_VS;
               end
            end
            ST_MUTE_FRAME: begin
               if (fs_s && mismatch_s) begin
                  dly_active_r <= eff_dly_s;
                  src_active_r <= src_sel;
                  state_r      <= ST_MUTE_FRAME;
                  realign_r    <= 1'b1;
               end else if (fs_s) begin
                  state_r      <= ST_RUN;
                  realign_r    <= 1'b0;
               end else begin
                  state_r      <= ST_MUTE_FRAME;
                  realign_r    <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_WAIT_VS;
               realign_r <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: a directed frame schedule pushes expected outputs
// per cycle, and a negedge monitor pops and compares them.
module tb_pixel_compositor;
   localparam int H_TOT = 1040;
   localparam int H_ACT = 1024;
   localparam int F_TOT = 3 * H_TOT;
   localparam int N_CYC = 41700;

   logic        clk;
   logic        reset;
   logic [1:0]  src_sel;
   logic [23:0] live_pixel;
   logic [5:0]  live_dly;
   logic [7:0]  bram_dout;
   logic        in_display;
   logic [95:0] layer_pix;
   logic [3:0]  layer_en;
   logic        hsync, vsync, blank;
   logic [23:0] pixel_out;
   logic        hsync_out, vsync_out, blank_out, realign;
   logic [5:0]  dly_active;

   typedef struct {
      int          n;
      logic        pchk;
      logic [23:0] pix;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        rl;
      logic [5:0]  dly;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [23:0] cur_live;
   logic [23:0] bar_tab [8];

   pixel_compositor dut (
      .clk(clk), .reset(reset), .src_sel(src_sel), .live_pixel(live_pixel),
      .live_dly(live_dly), .bram_dout(bram_dout), .in_display(in_display),
      .layer_pix(layer_pix), .layer_en(layer_en), .hsync(hsync), .vsync(vsync),
      .blank(blank), .pixel_out(pixel_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .blank_out(blank_out), .realign(realign),
      .dly_active(dly_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raw timing {hsync, vsync, blank}: 1040-cycle lines, two active lines then one blank line.
   function automatic logic [2:0] gen_sync(input int k);
      int p, ln, x;
      p  = k % F_TOT;
      ln = p / H_TOT;
      x  = p % H_TOT;
      return {!(x >= 1028 && x < 1032), !(ln == 2 && x < 20), (x >= H_ACT) || (ln == 2)};
   endfunction

   // Frame starts fall at cycles 2080 + 3120*j; these tables follow the directed schedule.
   function automatic int dly_after(input int k);
      if (k < 2080)       return 0;
      else if (k < 8320)  return 10;
      else if (k < 30160) return 20;
      else if (k < 33999) return 63;
      else if (k < 36400) return 0;
      else                return 63;
   endfunction

   function automatic logic rl_after(input int k);
      if (k < 5200)       return 1'b1;
      else if (k < 6500)  return 1'b0;
      else if (k < 11440) return 1'b1;
      else if (k < 11900) return 1'b0;
      else if (k < 17680) return 1'b1;
      else if (k < 18000) return 1'b0;
      else if (k < 23920) return 1'b1;
      else if (k < 27100) return 1'b0;
      else if (k < 33280) return 1'b1;
      else if (k < 33999) return 1'b0;
      else if (k < 39520) return 1'b1;
      else                return 1'b0;
   endfunction

   function automatic logic [1:0] src_after(input int k);
      if (k < 2080)       return 2'd2;
      else if (k < 14560) return 2'd0;
      else if (k < 20800) return 2'd1;
      else if (k < 33999) return 2'd3;
      else if (k < 36400) return 2'd2;
      else                return 2'd3;
   endfunction

   function automatic logic in_rst(input int k);
      return (k < 5) || (k >= 33999 && k <= 34003);
   endfunction

   task automatic apply(input int k);
      logic [2:0] s;
      reset = !((k < 5) || (k >= 34000 && k <= 34003));
      s = gen_sync(k);
      hsync = s[2]; vsync = s[1]; blank = s[0];
      if (k < 6500)       live_dly = 6'd10;
      else if (k < 7000)  live_dly = 6'd20;
      else if (k < 8000)  live_dly = 6'd15;
      else if (k < 27100) live_dly = 6'd20;
      else                live_dly = 6'd63;
      if (k < 11900)      src_sel = 2'd0;
      else if (k < 18000) src_sel = 2'd1;
      else                src_sel = 2'd3;
      bram_dout  = 8'b101_011_10;
      in_display = (k < 17850);
      layer_en   = 4'b0000;
      layer_pix  = 96'h0;
      if (k < 11000) begin
         live_pixel = 24'(k * 7919 + 1234567);
         cur_live   = live_pixel;
      end else begin
         live_pixel = 24'h123456;
         layer_pix[48 +: 24] = 24'hFF0000;
         if (k < 11600) begin
            layer_en = 4'b0110; layer_pix[24 +: 24] = 24'h00FF00; cur_live = 24'h00FF00;
         end else if (k < 11700) begin
            layer_en = 4'b0110; cur_live = 24'hFF0000;
         end else if (k < 11800) begin
            layer_pix[24 +: 24] = 24'h00FF00; cur_live = 24'h123456;
         end else if (k < 11850) begin
            layer_en = 4'b1111; layer_pix[0 +: 24] = 24'hABCDEF;
            layer_pix[72 +: 24] = 24'h010101; cur_live = 24'hABCDEF;
         end else begin
            layer_en = 4'b1000; layer_pix[0 +: 24] = 24'hABCDEF;
            layer_pix[72 +: 24] = 24'h010101; cur_live = 24'h010101;
         end
      end
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      logic [2:0] s;
      int d, p;
      e.n = k; e.pchk = 1'b1; e.pix = 24'h0;
      if (in_rst(k)) begin
         e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.rl = 1'b1; e.dly = 6'd0;
      end else begin
         d = dly_after(k - 1);
         s = gen_sync(k - d);
         e.hs = s[2]; e.vs = s[1]; e.bl = s[0];
         e.rl  = rl_after(k);
         e.dly = 6'(dly_after(k));
         if (!rl_after(k - 1)) begin
            case (src_after(k - 1))
               2'd0: e.pix = cur_live;
               2'd1: e.pix = in_display ? 24'hA06080 : 24'hFFFFFF;
               2'd3: begin
                  p = (k - d) % F_TOT;
                  if (s[0]) e.pchk = 1'b0;
                  else      e.pix  = bar_tab[(p % H_TOT) >> 7];
               end
               default: e.pix = 24'h0;
            endcase
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic chk(input string nm, input int n, input logic [23:0] act, input logic [23:0] want);
      if (act !== want) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h, want %h", nm, n, act, want);
      end
   endtask

   // Monitor: compares every queued expectation against the settled outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (e.pchk) chk("pixel_out", e.n, pixel_out, e.pix);
            chk("hsync_out",  e.n, {23'd0, hsync_out}, {23'd0, e.hs});
            chk("vsync_out",  e.n, {23'd0, vsync_out}, {23'd0, e.vs});
            chk("blank_out",  e.n, {23'd0, blank_out}, {23'd0, e.bl});
            chk("realign",    e.n, {23'd0, realign},   {23'd0, e.rl});
            chk("dly_active", e.n, {18'd0, dly_active}, {18'd0, e.dly});
         end
      end
   end

   // Driver: inputs change 1 time unit after each rising edge.
   initial begin
      bar_tab = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                  24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
      for (int k = 0; k < N_CYC; k++) begin
         apply(k);
         @(posedge clk);
         push_exp(k);
         #1;
      end
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Parametrised successor to the fixed-latency pixel output selector, placed between the colour-processing chain and the VGA driver.
- Chooses the frame source: live processed pixel, BRAM playback, mute, or built-in colour bars. Composites NUM_LAYERS overlay layers over live video in fixed priority.
- Aligns hsync/vsync/blank to a runtime-selectable pipeline latency.
- Latency or source changes take effect only at a frame boundary, followed by one muted frame, so no tearing occurs mid-frame.

Parameters:
- PIX_W, 24, output pixel width; three equal channels of PIX_W/3 bits each.
- NUM_LAYERS, 4, number of overlay layers.
- MAX_DLY, 64, sync delay-line depth.
- DLY_W, 6, width of the latency select; equals clog2(MAX_DLY).
- BAR_SHIFT, 7, log2 of colour-bar width in pixels.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- src_sel  in  2  0=LIVE, 1=BRAM, 2=MUTE, 3=BARS.
- live_pixel  in  PIX_W  processed pixel, already aligned to its latency.
- live_dly  in  DLY_W  latency in cycles of live_pixel relative to the raw syncs.
- bram_dout  in  8  stored pixel in RRRGGGBB format.
- in_display  in  1  BRAM read address is inside the stored image.
- layer_pix  in  NUM_LAYERS*PIX_W  overlay pixels; layer i occupies bits [i*PIX_W +: PIX_W].
- layer_en  in  NUM_LAYERS  per-layer enable.
- hsync, vsync, blank  in  1 each  raw timing; hsync/vsync active-low, blank active-high.
- pixel_out  out  PIX_W  registered output pixel.
- hsync_out, vsync_out, blank_out  out  1 each  aligned timing.
- realign  out  1  high while a source/latency change is pending or while the muted frame is shown.
- dly_active  out  DLY_W  latency currently applied.

Behaviour:
- Reset (reset=0), asynchronous:
  - pixel_out=0; hsync_out=1, vsync_out=1, blank_out=1.
  - All delay-line stages preset to idle (1,1,1).
  - dly_active=0; src_active=MUTE; state=WAIT_VS; realign=1.
- Clamp: eff_dly = min(live_dly, MAX_DLY-1).
- Frame start (fs): vsync==0 and registered vsync_q==1, i.e. a falling edge.
- Sync path: the MAX_DLY-stage shift line is tapped at dly_active, followed by the output register. For example, hsync_out(t) = hsync(t-dly_active-1); dly_active=0 gives 1 cycle.
- Pixel path: single output register, so live_pixel presented at t appears at t+1. Latency relative to the raw syncs is dly_active+1, matching the sync path.
- mismatch = (eff_dly != dly_active) or (src_sel != src_active).
- FSM:
  - RUN, realign=0:
    - mismatch and not fs -> WAIT_VS.
    - mismatch and fs -> latch dly_active=eff_dly and src_active=src_sel, go to MUTE_FRAME.
  - WAIT_VS, realign=1, output muted:
    - on fs -> latch dly_active and src_active, go to MUTE_FRAME.
    - inputs changing while waiting: the value latched is the value sampled at fs.
  - MUTE_FRAME, realign=1, output muted:
    - on fs with mismatch -> re-latch and stay in MUTE_FRAME.
    - on fs without mismatch -> RUN.
- Syncs are never muted. The tap switches on the cycle after the latch; a one-time sync discontinuity at the frame boundary is accepted.
- Pixel select, registered, when state==RUN:
  - LIVE: first i ascending (layer 0 = highest priority) with layer_en[i] and layer_pix[i]!=0 supplies the pixel; otherwise live_pixel.
  - BRAM: if in_display, each channel gets bram_dout bits (R=[7:5], G=[4:2], B=[1:0]) in its MSBs with the rest zero; otherwise all-ones.
  - MUTE: 0.
  - BARS: col counter clears while the aligned blank tap is 1 and increments each cycle it is 0. idx = col>>BAR_SHIFT (3 LSBs). R/G/B channel = all-ones if idx[2]/idx[1]/idx[0] else 0.
- In any state other than RUN, pixel_out=0.
- Reset asserted mid-frame: immediate return to reset values. The next fs latches the current inputs.

Test Plan:
- Reset release with live_dly=10, src_sel=LIVE:
  - realign=1 until the first vsync fall plus one full frame; pixels 0 throughout.
  - Then RUN: blank_out equals blank delayed 11 cycles, and pixel_out equals live_pixel delayed 1.
- In RUN, live_dly changes 10->20 mid-frame:
  - realign rises next cycle; dly_active stays 10 until fs, then becomes 20.
  - One frame of zeros, then RUN with a 21-cycle sync delay.
- Overlay priority: layer_en=4'b0110, layer1=0x00FF00, layer2=0xFF0000, live=0x123456 -> 0x00FF00. With layer1=0 -> 0xFF0000. With layer_en=0 -> 0x123456.
- BRAM source, bram_dout=8'b101_011_10:
  - in_display=1 -> 0xA0_60_80.
  - in_display=0 -> 0xFFFFFF.
- BARS, BAR_SHIFT=7: active pixels 0..127 -> 0x000000; 128..255 -> 0x0000FF; 896..1023 -> 0xFFFFFF. Column counter restarts each line.
- live_dly=63 with MAX_DLY=64: eff_dly=63, sync delay 64. Then reset pulsed low mid-frame -> outputs idle at once, dly_active=0.
